// File: rtl/quiz_judge.sv
// quiz_judge: round controller and BCD scorekeeper for the two-player quiz game.
// Registers the decoded (answer, player) pair, filters it for stability, arbitrates
// the first valid responder, judges it against the latched key and keeps 00-99 scores.
module quiz_judge #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SHOW_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] anssel,
  input  logic [1:0] player,
  input  logic [2:0] key,
  input  logic       round_start,
  input  logic       score_clr,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic [1:0] winner,
  output logic [1:0] lockout,
  output logic       armed,
  output logic       show
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_JUDGE, S_SHOW} state_e;

  localparam logic [7:0]  STABLE_W  = 8'(STABLE_CYCLES);
  localparam logic [15:0] SHOW_LAST = 16'(SHOW_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  ans_q, last_ans_q;
  logic [1:0]  ply_q, last_ply_q;
  logic [2:0]  cand_ans_q, cand_ans_d;
  logic [1:0]  cand_ply_q, cand_ply_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] show_cnt_q, show_cnt_d;
  logic [2:0]  key_q, key_d;
  logic [1:0]  winner_q, winner_d;
  logic [1:0]  lockout_q, lockout_d;
  logic [7:0]  s1_q, s1_d;   // {tens, ones}
  logic [7:0]  s2_q, s2_d;   // {tens, ones}

  logic       pair_valid, pair_same, key_ok;
  logic [1:0] lock_wrong;

  // Saturating two-digit BCD increment: 09 -> 10, 99 stays 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)        return s;
    if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  // A pair counts only if it names an answer, a player, and that player may still answer.
  assign pair_valid = (ans_q >= 3'd1) && (ans_q <= 3'd4) &&
                      (((ply_q == 2'd1) && !lockout_q[0]) ||
                       ((ply_q == 2'd2) && !lockout_q[1]));
  assign pair_same  = (ans_q == last_ans_q) && (ply_q == last_ply_q);
  assign key_ok     = (key >= 3'd1) && (key <= 3'd4);
  assign lock_wrong = lockout_q | ((cand_ply_q == 2'd1) ? 2'b01 : 2'b10);

  // Input pair register plus a one-cycle history copy for the stability comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ans_q      <= '0;
      ply_q      <= '0;
      last_ans_q <= '0;
      last_ply_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      ans_q      <= anssel;
      ply_q      <= player;
      last_ans_q <= ans_q;
      last_ply_q <= ply_q;
    end
  end

  // Round state, filter, show timer, key, result and score registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cand_ans_q <= '0;
      cand_ply_q <= '0;
      cnt_q      <= '0;
      show_cnt_q <= '0;
      key_q      <= '0;
      winner_q   <= '0;
      lockout_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      state_q    <= state_d;
      cand_ans_q <= cand_ans_d;
      cand_ply_q <= cand_ply_d;
      cnt_q      <= cnt_d;
      show_cnt_q <= show_cnt_d;
      key_q      <= key_d;
      winner_q   <= winner_d;
      lockout_q  <= lockout_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  // Next-state logic: arming, stability filter, judging, result hold and score clear.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cand_ans_d = cand_ans_q;
    cand_ply_d = cand_ply_q;
    cnt_d      = '0;
    show_cnt_d = '0;
    key_d      = key_q;
    winner_d   = winner_q;
    lockout_d  = lockout_q;
    s1_d       = s1_q;
    s2_d       = s2_q;

    case (state_q)
      S_IDLE: begin
        if (round_start) begin
          key_d = key;
          if (key_ok) begin
            lockout_d = '0;
            winner_d  = '0;
            state_d   = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (round_start) begin
          // Restart: new key, lockouts cleared, filter emptied (cnt_d default 0).
          key_d     = key;
          lockout_d = '0;
        end else if (cnt_q == STABLE_W) begin
          state_d = S_JUDGE;
        end else if (pair_valid) begin
          // A fresh pair starts the run at 1; the same pair keeps counting.
          cnt_d      = pair_same ? cnt_q + 8'd1 : 8'd1;
          cand_ans_d = ans_q;
          cand_ply_d = ply_q;
        end
      end
      S_JUDGE: begin
        if (cand_ans_q == key_q) begin
          winner_d = cand_ply_q;
          state_d  = S_SHOW;
          if (cand_ply_q == 2'd1) s1_d = bcd_inc(s1_q);
          else                    s2_d = bcd_inc(s2_q);
        end else begin
          lockout_d = lock_wrong;
          if (&lock_wrong) begin
            winner_d = '0;
            state_d  = S_SHOW;
          end else begin
            state_d  = S_ARMED;
          end
        end
      end
      S_SHOW: begin
        if (show_cnt_q == SHOW_LAST) state_d = S_IDLE;
        else                         show_cnt_d = show_cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear takes priority over any increment made in the same cycle.
    if (score_clr) begin
      s1_d = '0;
      s2_d = '0;
    end
  end

  assign p1_tens = s1_q[7:4];
  assign p1_ones = s1_q[3:0];
  assign p2_tens = s2_q[7:4];
  assign p2_ones = s2_q[3:0];
  assign winner  = winner_q;
  assign lockout = lockout_q;
  assign armed   = (state_q == S_ARMED);
  assign show    = (state_q == S_SHOW);

endmodule

// File: tb/tb_quiz_judge.sv
// tb_quiz_judge: directed scenarios plus randomized play, every cycle compared against
// a behavioural model that keeps scores as plain integers and the round as a mode number.
module tb_quiz_judge;

  localparam int STABLE = 4;
  localparam int SHOW   = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_JUDGE = 2, M_SHOW = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] anssel, key;
  logic [1:0] player;
  logic       round_start, score_clr;
  logic [3:0] p1_tens, p1_ones, p2_tens, p2_ones;
  logic [1:0] winner, lockout;
  logic       armed, show;
  logic [21:0] dut_outs;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_mode, m_key, m_win, m_streak, m_show_left;
  int m_ra, m_rp, m_la, m_lp, m_ca, m_cp;
  int m_score [1:2];
  bit m_lock  [1:2];

  quiz_judge #(.STABLE_CYCLES(STABLE), .SHOW_CYCLES(SHOW)) dut (
    .clk(clk), .rst(rst), .anssel(anssel), .player(player), .key(key),
    .round_start(round_start), .score_clr(score_clr),
    .p1_tens(p1_tens), .p1_ones(p1_ones), .p2_tens(p2_tens), .p2_ones(p2_ones),
    .winner(winner), .lockout(lockout), .armed(armed), .show(show)
  );

  assign dut_outs = {p1_tens, p1_ones, p2_tens, p2_ones, winner, lockout, armed, show};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_key = 0; m_win = 0; m_streak = 0; m_show_left = 0;
    m_ra = 0; m_rp = 0; m_la = 0; m_lp = 0; m_ca = 0; m_cp = 0;
    m_score[1] = 0; m_score[2] = 0; m_lock[1] = 0; m_lock[2] = 0;
  endtask

  // One clock edge of the game rules, using the inputs present at that edge.
  task automatic model_step();
    bit v, same;
    int n_mode, n_streak;
    v = (m_ra >= 1 && m_ra <= 4) &&
        ((m_rp == 1 && !m_lock[1]) || (m_rp == 2 && !m_lock[2]));
    same = (m_ra == m_la) && (m_rp == m_lp);
    n_mode = m_mode;
    n_streak = 0;
    case (m_mode)
      M_IDLE: if (round_start) begin
        m_key = int'(key);
        if (m_key >= 1 && m_key <= 4) begin
          m_lock[1] = 0; m_lock[2] = 0; m_win = 0; n_mode = M_ARMED;
        end
      end
      M_ARMED: begin
        if (round_start) begin
          m_key = int'(key); m_lock[1] = 0; m_lock[2] = 0;
        end else if (m_streak == STABLE) begin
          n_mode = M_JUDGE;
        end else if (v) begin
          n_streak = same ? m_streak + 1 : 1;
          m_ca = m_ra; m_cp = m_rp;
        end
      end
      M_JUDGE: begin
        if (m_ca == m_key) begin
          if (m_score[m_cp] < 99) m_score[m_cp] = m_score[m_cp] + 1;
          m_win = m_cp; n_mode = M_SHOW; m_show_left = SHOW;
        end else begin
          m_lock[m_cp] = 1;
          if (m_lock[1] && m_lock[2]) begin
            m_win = 0; n_mode = M_SHOW; m_show_left = SHOW;
          end else n_mode = M_ARMED;
        end
      end
      default: begin
        m_show_left = m_show_left - 1;
        if (m_show_left == 0) n_mode = M_IDLE;
      end
    endcase
    if (score_clr) begin m_score[1] = 0; m_score[2] = 0; end
    m_la = m_ra; m_lp = m_rp;
    m_ra = int'(anssel); m_rp = int'(player);
    m_mode = n_mode; m_streak = n_streak;
  endtask

  function automatic logic [21:0] model_outs();
    return {4'(m_score[1] / 10), 4'(m_score[1] % 10), 4'(m_score[2] / 10), 4'(m_score[2] % 10),
            2'(m_win), m_lock[2], m_lock[1], m_mode == M_ARMED, m_mode == M_SHOW};
  endfunction

  // Advance the model on each edge and compare all outputs shortly after it.
  always @(posedge clk) begin
    if (rst) model_reset();
    else     model_step();
    #1;
    check("outputs", 32'(dut_outs), 32'(model_outs()));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pair(input int a, input int p);
    anssel = 3'(a);
    player = 2'(p);
  endtask

  task automatic start_round(input int k);
    round_start = 1'b1;
    key = 3'(k);
    @(negedge clk);
    round_start = 1'b0;
  endtask

  task automatic wait_mode(input int mode, input string tag);
    int n = 0;
    while (m_mode != mode && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 300), 32'd1);
  endtask

  task automatic win_round(input int k, input int a, input int p);
    set_pair(a, p);
    start_round(k);
    wait_mode(M_IDLE, "round_timeout");
    set_pair(0, 0);
    tick(1);
  endtask

  task automatic clear_scores();
    score_clr = 1'b1;
    tick(1);
    score_clr = 1'b0;
  endtask

  initial begin
    int hold, n;
    model_reset();
    rst = 1'b1; anssel = '0; player = '0; key = '0; round_start = 1'b0; score_clr = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("reset_outs", 32'(dut_outs), 32'd0);

    // Correct answer: 6 cycles to score, then SHOW for SHOW cycles.
    set_pair(3, 1);
    start_round(3);
    tick(5);
    check("pre_score_p1", {p1_tens, p1_ones}, 8'h00);
    tick(1);
    check("correct_p1", {p1_tens, p1_ones}, 8'h01);
    check("correct_winner", 32'(winner), 32'd1);
    n = 0;
    while (show && n < 40) begin n++; @(negedge clk); end
    check("show_len", 32'(n), 32'(SHOW));
    check("back_idle", {armed, show}, 2'b00);
    set_pair(0, 0);

    // Glitch rejection, then a held press from P2.
    start_round(2);
    set_pair(2, 2); tick(3); set_pair(0, 0); tick(8);
    check("glitch_armed", 32'(armed), 32'd1);
    set_pair(2, 2);
    wait_mode(M_IDLE, "glitch_round_timeout");
    check("glitch_p2", {p2_tens, p2_ones}, 8'h01);
    set_pair(0, 0); tick(1);

    // Lockout of P1, P1 keeps holding the right answer, P2 then wins.
    set_pair(1, 1); start_round(4); tick(8);
    check("lock_p1", 32'(lockout), 32'd1);
    check("lock_armed", 32'(armed), 32'd1);
    set_pair(4, 1); tick(10);
    check("held_ignored", {lockout, armed}, 3'b011);
    set_pair(4, 2);
    wait_mode(M_IDLE, "lock_round_timeout");
    check("lock_p2_score", {p2_tens, p2_ones}, 8'h02);
    check("lock_winner", 32'(winner), 32'd2);
    set_pair(0, 0); tick(1);

    // Both wrong: no winner, scores unchanged.
    set_pair(1, 1); start_round(4); tick(8);
    set_pair(2, 2); tick(8);
    check("both_wrong", {lockout, winner, show}, 5'b11001);
    check("both_wrong_scores", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h0102);
    wait_mode(M_IDLE, "both_wrong_timeout");
    set_pair(0, 0); tick(1);

    // BCD carry and saturation.
    clear_scores();
    repeat (9) win_round(1, 1, 1);
    check("p1_09", {p1_tens, p1_ones}, 8'h09);
    win_round(1, 1, 1);
    check("p1_carry", {p1_tens, p1_ones}, 8'h10);
    for (int i = 0; i < 100 && m_score[1] < 99; i++) win_round(2, 2, 1);
    check("p1_99", {p1_tens, p1_ones}, 8'h99);
    win_round(2, 2, 1);
    check("p1_sat", {p1_tens, p1_ones}, 8'h99);

    // Clear colliding with a JUDGE increment.
    set_pair(2, 1); start_round(2);
    wait_mode(M_JUDGE, "judge_timeout");
    score_clr = 1'b1; tick(1); score_clr = 1'b0;
    check("clr_collision", {p1_tens, p1_ones, 2'b00, winner}, 12'h001);
    wait_mode(M_IDLE, "clr_round_timeout");
    set_pair(0, 0); tick(1);

    // Asynchronous reset mid-ARMED with scores 12/34.
    repeat (12) win_round(3, 3, 1);
    repeat (34) win_round(3, 3, 2);
    check("pre_reset_scores", {p1_tens, p1_ones, p2_tens, p2_ones}, 16'h1234);
    start_round(1); tick(2);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(dut_outs), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick(2);
    check("idle_after_reset", {armed, show}, 2'b00);
    start_round(0); tick(3);
    check("bad_key_idle", 32'(armed), 32'd0);

    // Randomized play.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        set_pair(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      round_start = ($urandom_range(0, (m_mode == M_IDLE) ? 3 : 40) == 0);
      key         = 3'($urandom_range(0, 5));
      score_clr   = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    round_start = 1'b0; score_clr = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
